// File: rtl/loss_averager.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | loss_averager: per-lane averaging of 2^LOG2_AVG consecutive beats.      |
// | Optional macro LOSS_AVERAGER_ROUND_EN selects round-half-up. Rev 1.0    |
// +------------------------------------------------------------------------+
module loss_averager #(
  parameter int DATA_WIDTH  = 256,
  parameter int WORD_WIDTH  = 16,
  parameter int LOG2_AVG    = 2,
  parameter int GAP_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] comp_tdata,
  input  logic                  comp_tvalid,
  output logic                  comp_tready,
  input  logic                  avg_clear,
  output logic [DATA_WIDTH-1:0] avg_tdata,
  output logic                  avg_tvalid,
  input  logic                  avg_tready,
  output logic [15:0]           drop_count
);

  localparam int c_lanes = DATA_WIDTH / WORD_WIDTH;
  localparam int c_acc_w = WORD_WIDTH + LOG2_AVG + 1;
  localparam logic [LOG2_AVG-1:0] c_last_beat = '1;
  localparam logic [7:0] c_gap_limit = 8'(GAP_TIMEOUT);
`ifdef LOSS_AVERAGER_ROUND_EN
  localparam logic [c_acc_w-1:0] c_round = c_acc_w'(1) << (LOG2_AVG - 1);
`else
  localparam logic [c_acc_w-1:0] c_round = '0;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_load;
  logic                  w_add;
  logic                  w_done;
  logic                  w_drop;
  logic [LOG2_AVG-1:0]   r_beat;
  logic [7:0]            r_gap;
  logic [7:0]            w_gap_inc;
  logic                  r_ready;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_avg;
  logic [15:0]           r_drop;
  logic                  w_unused_tready;

  // The output side never stalls, so its ready is intentionally ignored.
  assign w_unused_tready = avg_tready;
  assign w_gap_inc       = r_gap + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_done      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!avg_clear && comp_tvalid) begin
          w_load      = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (avg_clear) begin
          w_drop      = 1'b1;
          w_state_nxt = IDLE;
        end else if (comp_tvalid) begin
          if (r_beat == c_last_beat) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_add = 1'b1;
          end
        end else if (w_gap_inc == c_gap_limit) begin
          w_drop      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat  <= '0;
      r_gap   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_drop  <= '0;
    end else begin
      r_ready <= 1'b1;
      r_valid <= w_done;
      r_data  <= w_done ? w_avg : '0;
      if (w_load) begin
        r_beat <= LOG2_AVG'(1);
        r_gap  <= '0;
      end else if (w_add) begin
        r_beat <= r_beat + LOG2_AVG'(1);
        r_gap  <= '0;
      end else if (r_state == ACCUM && !comp_tvalid) begin
        r_gap <= w_gap_inc;
      end
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  for (genvar g = 0; g < c_lanes; g++) begin : g_lane
    logic [WORD_WIDTH-1:0] w_word;
    logic [c_acc_w-1:0]    r_acc;
    logic [c_acc_w-1:0]    w_sum;

    assign w_word = comp_tdata[g*WORD_WIDTH +: WORD_WIDTH];
    // Accumulator is one bit wider than the full group sum needs, so adding
    // the final beat and the rounding term cannot overflow.
    assign w_sum  = r_acc + c_acc_w'(w_word) + c_round;
    assign w_avg[g*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(w_sum >> LOG2_AVG);

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_acc <= '0;
      else if (w_load) r_acc <= c_acc_w'(w_word);
      else if (w_add)  r_acc <= r_acc + c_acc_w'(w_word);
    end
  end

  assign comp_tready = r_ready;
  assign avg_tvalid  = r_valid;
  assign avg_tdata   = r_data;
  assign drop_count  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_loss_averager.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_loss_averager: scoreboard bench with a sum-and-divide group model.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_loss_averager;

  localparam int DW    = 256;
  localparam int WW    = 16;
  localparam int LANES = DW / WW;
  localparam int L     = 2;
  localparam int N     = 4;
  localparam int GAP   = 8;
`ifdef LOSS_AVERAGER_ROUND_EN
  localparam int RND = N / 2;
`else
  localparam int RND = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] comp_tdata = '0;
  logic          comp_tvalid = 1'b0;
  logic          comp_tready;
  logic          avg_clear = 1'b0;
  logic [DW-1:0] avg_tdata;
  logic          avg_tvalid;
  logic          avg_tready = 1'b1;
  logic [15:0]   drop_count;

  loss_averager #(
    .DATA_WIDTH (DW),
    .WORD_WIDTH (WW),
    .LOG2_AVG   (L),
    .GAP_TIMEOUT(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .comp_tdata (comp_tdata),
    .comp_tvalid(comp_tvalid),
    .comp_tready(comp_tready),
    .avg_clear  (avg_clear),
    .avg_tdata  (avg_tdata),
    .avg_tvalid (avg_tvalid),
    .avg_tready (avg_tready),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          ncyc = 0;
  int          n_out = 0;
  int          last_out_cyc = -100;
  int          prev_out_cyc = -100;
  logic [DW-1:0] last_avg = '0;

  // Reference model state: running per-lane sums of the current group.
  int unsigned m_sum[LANES];
  int          m_cnt = 0;
  int          m_gap = 0;
  int          m_drop = 0;
  logic        m_ready = 1'b0;

  function automatic void chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic logic [DW-1:0] fill(input logic [WW-1:0] v);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*WW +: WW] = v;
    return r;
  endfunction

  function automatic void bump_drop();
    if (m_drop < 16'hFFFF) m_drop++;
  endfunction

  function automatic void model_reset();
    m_cnt   = 0;
    m_gap   = 0;
    m_drop  = 0;
    m_ready = 1'b0;
    sb.delete();
  endfunction

  function automatic void model_step(input logic v, input logic [DW-1:0] d, input logic c);
    exp_t e;
    m_ready = 1'b1;
    if (c) begin
      if (m_cnt > 0) bump_drop();
      m_cnt = 0;
    end else if (v) begin
      for (int l = 0; l < LANES; l++) begin
        if (m_cnt == 0) m_sum[l] = 0;
        m_sum[l] += d[l*WW +: WW];
      end
      m_cnt++;
      m_gap = 0;
      if (m_cnt == N) begin
        for (int l = 0; l < LANES; l++) e.data[l*WW +: WW] = WW'((m_sum[l] + RND) / N);
        e.stamp = ncyc;
        sb.push_back(e);
        m_cnt = 0;
      end
    end else if (m_cnt > 0) begin
      m_gap++;
      if (m_gap == GAP) begin
        bump_drop();
        m_cnt = 0;
      end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    chk("comp_tready", DW'(comp_tready), DW'(m_ready));
    chk("drop_count", DW'(drop_count), DW'(m_drop));
    if (avg_tvalid) begin
      n_out++;
      prev_out_cyc = last_out_cyc;
      last_out_cyc = ncyc;
      last_avg     = avg_tdata;
      if (sb.size() == 0) begin
        chk("avg_tvalid_unexpected", DW'(avg_tvalid), '0);
      end else begin
        e = sb.pop_front();
        chk("avg_tdata", avg_tdata, e.data);
        chk("avg_latency_cycle", DW'(ncyc), DW'(e.stamp));
      end
    end else begin
      chk("avg_tdata_idle_zero", avg_tdata, '0);
      if (sb.size() > 0 && sb[0].stamp <= ncyc) begin
        chk("avg_tvalid_missing", DW'(avg_tvalid), DW'(1));
        void'(sb.pop_front());
      end
    end
    ncyc++;
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic c);
    comp_tvalid = v;
    comp_tdata  = d;
    avg_clear   = c;
    @(posedge clk);
    if (!rst) model_step(v, d, c);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    comp_tvalid = 1'b0;
    avg_clear   = 1'b0;
    rst         = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) begin
      case ($urandom_range(0, 9))
        0, 1:    r[l*WW +: WW] = 16'hFFFF;
        2:       r[l*WW +: WW] = 16'h0000;
        default: r[l*WW +: WW] = WW'($urandom);
      endcase
    end
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    #1;
    chk("reset_tready", DW'(comp_tready), '0);
    chk("reset_tvalid", DW'(avg_tvalid), '0);
    chk("reset_tdata", avg_tdata, '0);
    chk("reset_drop", DW'(drop_count), '0);
    do_reset();

    // 10,11,12,13 -> 46/4
    base = n_out;
    for (int k = 0; k < 4; k++) drive(1'b1, fill(WW'(10 + k)), 1'b0);
    idle(2);
    chk("r029_count", DW'(n_out - base), DW'(1));
`ifdef LOSS_AVERAGER_ROUND_EN
    chk("r029_value", last_avg, fill(16'd12));
`else
    chk("r029_value", last_avg, fill(16'd11));
`endif

    repeat (4) drive(1'b1, fill(16'hFFFF), 1'b0);
    idle(2);
    chk("r030_value", last_avg, fill(16'hFFFF));

    do_reset();
    base = n_out;
    repeat (3) drive(1'b1, fill(16'd9), 1'b0);
    idle(GAP);
    repeat (4) drive(1'b1, fill(16'd5), 1'b0);
    idle(2);
    chk("r031_drop", DW'(drop_count), DW'(1));
    chk("r031_count", DW'(n_out - base), DW'(1));
    chk("r031_value", last_avg, fill(16'd5));

    do_reset();
    base = n_out;
    repeat (3) drive(1'b1, fill(16'd9), 1'b0);
    drive(1'b1, fill(16'd9), 1'b1);
    idle(2);
    chk("r032_no_out", DW'(n_out - base), '0);
    chk("r032_drop", DW'(drop_count), DW'(1));
    repeat (4) drive(1'b1, fill(16'd7), 1'b0);
    idle(2);
    chk("r032_value", last_avg, fill(16'd7));

    do_reset();
    base = n_out;
    repeat (8) drive(1'b1, fill(16'd2), 1'b0);
    idle(2);
    chk("r033_count", DW'(n_out - base), DW'(2));
    chk("r033_spacing", DW'(last_out_cyc - prev_out_cyc), DW'(4));
    chk("r033_value", last_avg, fill(16'd2));

    do_reset();
    drive(1'b1, fill(16'd1), 1'b0);
    drive(1'b0, '0, 1'b1);
    repeat (2) drive(1'b1, fill(16'd4), 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("r034_async_drop", DW'(drop_count), '0);
    chk("r034_async_tready", DW'(comp_tready), '0);
    chk("r034_async_tvalid", DW'(avg_tvalid), '0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = n_out;
    repeat (4) drive(1'b1, fill(16'd3), 1'b0);
    idle(2);
    chk("r034_count", DW'(n_out - base), DW'(1));
    chk("r034_value", last_avg, fill(16'd3));
    chk("r034_drop", DW'(drop_count), '0);

    // Randomized traffic with idle bursts around the timeout and clears.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        idle($urandom_range(GAP - 2, GAP + 2));
      end else begin
        drive($urandom_range(0, 9) < 7, rand_beat(), $urandom_range(0, 29) == 0);
      end
    end
    idle(4);
    chk("sb_drain", DW'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/loss_averager.md
LOSS_AVERAGER -- requirements
Module: loss_averager

Interface
REQ-001 Parameter DATA_WIDTH, default 256, sets the input and output bus width in bits.
REQ-002 Parameter WORD_WIDTH, default 16, sets the lane width; lanes = DATA_WIDTH/WORD_WIDTH.
REQ-003 Parameter LOG2_AVG, default 2, sets the group length N = 2^LOG2_AVG beats; legal range is 1..8.
REQ-004 Parameter GAP_TIMEOUT, default 8, sets the maximum idle cycles tolerated inside a group; legal range is 1..255.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port comp_tdata, input, DATA_WIDTH bits: loss-compensated samples, unsigned per lane.
REQ-008 Port comp_tvalid, input, 1 bit: comp_tdata is valid this cycle.
REQ-009 Port comp_tready, output, 1 bit: always 1 outside reset; the upstream stage does not stall.
REQ-010 Port avg_clear, input, 1 bit: synchronous pulse that discards the partial group.
REQ-011 Port avg_tdata, output, DATA_WIDTH bits: per-lane group average.
REQ-012 Port avg_tvalid, output, 1 bit: one-cycle strobe qualifying avg_tdata.
REQ-013 Port avg_tready, input, 1 bit: ignored; output is never back-pressured.
REQ-014 Port drop_count, output, 16 bits: number of partial groups discarded.

Function
REQ-015 Each lane shall have an unsigned accumulator of WORD_WIDTH+LOG2_AVG+1 bits and a shared beat counter of LOG2_AVG bits.
REQ-016 The FSM shall have states IDLE and ACCUM.
REQ-017 In IDLE, a beat with comp_tvalid=1 shall load each accumulator with its lane value, set beat count to 1 and the gap counter to 0, and enter ACCUM.
REQ-018 In ACCUM, a valid beat shall add each lane value to its accumulator, increment beat count and clear the gap counter.
REQ-019 The valid beat that completes N beats shall register avg_tdata lane = (accumulator + lane value [+ rounding]) >> LOG2_AVG, truncated to WORD_WIDTH, assert avg_tvalid on the next cycle, and return the FSM to IDLE.
REQ-020 Latency shall be 1 cycle from sampling the Nth beat to avg_tvalid=1, and groups shall be back-to-back capable, with no dead cycle between groups.
REQ-021 When no output is produced in a cycle, avg_tvalid shall be 0 and avg_tdata shall be all zeros.
REQ-022 In ACCUM, each cycle with comp_tvalid=0 shall increment the gap counter; on reaching GAP_TIMEOUT the partial group shall be discarded, drop_count incremented and the FSM returned to IDLE.
REQ-023 avg_clear=1 shall discard any partial group, return the FSM to IDLE and increment drop_count only if it was in ACCUM; a beat in the same cycle shall be ignored and no output produced, so clear wins.
REQ-024 drop_count shall saturate at 0xFFFF.
REQ-025 N=2 with LOG2_AVG=1 shall behave identically under the same rules.

Reset
REQ-026 Asserting rst shall immediately set the FSM to IDLE and clear accumulators, counters, avg_tdata, avg_tvalid and drop_count, and shall drive comp_tready to 0.
REQ-027 On the first clk edge after rst deasserts, comp_tready shall be 1, and a reset mid-group shall produce no output for that group.

Configuration
REQ-028 With macro LOSS_AVERAGER_ROUND_EN defined, 2^(LOG2_AVG-1) shall be added before the shift (round-half-up); without it, the result shall be truncated (floor).

Verification
REQ-029 N=4 with every lane given 10, 11, 12, 13 on consecutive cycles shall produce avg_tvalid for 1 cycle with lanes = 11, or 12 with ROUND_EN (46/4 = 11.5).
REQ-030 N=4, all lanes 0xFFFF for 4 beats shall produce lanes = 0xFFFF in both builds, with no overflow.
REQ-031 Three beats, then 8 idle cycles (GAP_TIMEOUT=8), then 4 beats of 5 shall give drop_count = 1 and a single output with lanes = 5.
REQ-032 avg_clear asserted together with the 4th beat shall give no avg_tvalid and drop_count = 1; a following 4 beats of 7 shall output 7.
REQ-033 Eight continuous beats of 2 shall produce two outputs of 2, spaced exactly 4 cycles apart.
REQ-034 rst asserted asynchronously after 2 beats shall clear all outputs immediately, and 4 subsequent beats of 3 shall output 3 with drop_count = 0.
